// File: rtl/sdc_pkg.sv
// Shared constants for the SD command-line engine: response encodings, CRC7, frame sizes, FSM states.
package sdc_pkg;

  // rsp_type encodings
  localparam logic [1:0] RSP_NONE        = 2'd0;
  localparam logic [1:0] RSP_SHORT       = 2'd1;
  localparam logic [1:0] RSP_LONG        = 2'd2;
  localparam logic [1:0] RSP_SHORT_NOCRC = 2'd3;

  // x^7 + x^3 + 1 (x^7 implicit)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // frame lengths in bits, including start and end bits
  localparam int unsigned CMD_FRAME_LEN = 48;
  localparam int unsigned RSP_SHORT_LEN = 48;
  localparam int unsigned RSP_LONG_LEN  = 136;
  // start, transmission, index and argument: the part of a command covered by CRC7
  localparam int unsigned CMD_HDR_LEN   = 40;

  // FSM state encoding
  typedef logic [2:0] sdc_state_t;
  localparam sdc_state_t ST_IDLE = 3'd0;
  localparam sdc_state_t ST_TX   = 3'd1;
  localparam sdc_state_t ST_TURN = 3'd2;
  localparam sdc_state_t ST_WAIT = 3'd3;
  localparam sdc_state_t ST_RX   = 3'd4;
  localparam sdc_state_t ST_GAP  = 3'd5;
  localparam sdc_state_t ST_DONE = 3'd6;

endpackage

// File: rtl/sdc_crc7.sv
// Serial CRC7 (x^7+x^3+1), one bit per enabled cycle, MSB first; clear wins over enable.
module sdc_crc7
  import sdc_pkg::*;
(
  input  logic       sd_clk,
  input  logic       sd_rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bitIn,
  output logic [6:0] crc
);

  logic feedback;

  assign feedback = bitIn ^ crc[6];

  // shift the LFSR by one bit when enabled
  always_ff @(posedge sd_clk or posedge sd_rst) begin
    if (sd_rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sdc_cmd_serial.sv
// SD command-line engine: sends a 48-bit command with CRC7, then captures and checks the card response.
module sdc_cmd_serial
  import sdc_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic         sd_clk,
  input  logic         sd_rst,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   rsp_type,
  output logic         busy,
  output logic         done,
  output logic [127:0] rsp_data,
  output logic         timeout,
  output logic         crc_err,
  output logic         index_err,
  output logic         end_err,
  output logic         cmd_o,
  output logic         cmd_oe,
  input  logic         cmd_i
);

  localparam int unsigned CNT_W      = $clog2(RSP_TIMEOUT + RSP_LONG_LEN + GAP_CYCLES + TURN_CYCLES + 1);
  localparam int unsigned RX_SHIFT_W = 127;
  localparam int unsigned CRC_LO     = 8;

  sdc_state_t          state, stateNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic [5:0]          idxReg, idxNext;
  logic [31:0]         argReg, argNext;
  logic [1:0]          typeReg, typeNext;
  logic [RX_SHIFT_W-1:0] rxShift, rxShiftNext;
  logic                busyNext, doneNext, timeoutNext, crcErrNext, indexErrNext, endErrNext;
  logic                cmdONext, cmdOeNext;
  logic [127:0]        rspDataNext;

  logic [CMD_HDR_LEN-1:0] header;
  logic [CNT_W-1:0]    txBit;
  logic [5:0]          hdrSel;
  logic [2:0]          crcSel;
  logic                txCrcClr, txCrcEn, txCrcBit;
  logic [6:0]          txCrc;
  logic                rxCrcClr, rxCrcEn;
  logic [6:0]          rxCrc;
  logic [CNT_W-1:0]    rxLast, rxCrcHi, rxBitNum;
  logic [127:0]        frameNext;

  // command header and bit selectors for the bit about to be driven
  assign header   = {2'b01, idxReg, argReg};
  assign txBit    = cnt + CNT_W'(1);
  assign hdrSel   = 6'((CMD_HDR_LEN - 1) - 32'(txBit));
  assign crcSel   = 3'((CMD_FRAME_LEN - 2) - 32'(txBit));
  assign txCrcBit = header[hdrSel];

  // response geometry: received bit number of the current RX cycle and CRC window
  assign rxLast    = (typeReg == RSP_LONG) ? CNT_W'(RSP_LONG_LEN - 2) : CNT_W'(RSP_SHORT_LEN - 2);
  assign rxCrcHi   = (typeReg == RSP_LONG) ? CNT_W'(127) : CNT_W'(RSP_SHORT_LEN - 2);
  assign rxBitNum  = rxLast - cnt;
  assign frameNext = {rxShift, cmd_i};

  sdc_crc7 u_txCrc (
    .sd_clk (sd_clk),
    .sd_rst (sd_rst),
    .clr    (txCrcClr),
    .en     (txCrcEn),
    .bitIn  (txCrcBit),
    .crc    (txCrc)
  );

  sdc_crc7 u_rxCrc (
    .sd_clk (sd_clk),
    .sd_rst (sd_rst),
    .clr    (rxCrcClr),
    .en     (rxCrcEn),
    .bitIn  (cmd_i),
    .crc    (rxCrc)
  );

  // next-state and next-output logic
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    idxNext      = idxReg;
    argNext      = argReg;
    typeNext     = typeReg;
    rxShiftNext  = rxShift;
    busyNext     = busy;
    doneNext     = 1'b0;
    rspDataNext  = rsp_data;
    timeoutNext  = timeout;
    crcErrNext   = crc_err;
    indexErrNext = index_err;
    endErrNext   = end_err;
    cmdONext     = cmd_o;
    cmdOeNext    = cmd_oe;
    txCrcClr     = 1'b0;
    txCrcEn      = 1'b0;
    rxCrcClr     = 1'b0;
    rxCrcEn      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          idxNext      = cmd_index;
          argNext      = cmd_arg;
          typeNext     = rsp_type;
          rxShiftNext  = '0;
          rspDataNext  = '0;
          timeoutNext  = 1'b0;
          crcErrNext   = 1'b0;
          indexErrNext = 1'b0;
          endErrNext   = 1'b0;
          busyNext     = 1'b1;
          cmdOeNext    = 1'b1;
          cmdONext     = 1'b0;
          cntNext      = '0;
          txCrcClr     = 1'b1;
          stateNext    = ST_TX;
        end
      end

      ST_TX: begin
        if (cnt == CNT_W'(CMD_FRAME_LEN - 1)) begin
          cmdOeNext = 1'b0;
          cmdONext  = 1'b1;
          cntNext   = '0;
          stateNext = ST_TURN;
        end else begin
          cntNext = cnt + CNT_W'(1);
          if (txBit < CNT_W'(CMD_HDR_LEN)) begin
            cmdONext = txCrcBit;
            txCrcEn  = 1'b1;
          end else if (txBit < CNT_W'(CMD_FRAME_LEN - 1)) begin
            cmdONext = txCrc[crcSel];
          end else begin
            cmdONext = 1'b1;
          end
        end
      end

      ST_TURN: begin
        if (cnt == CNT_W'(TURN_CYCLES - 1)) begin
          cntNext   = '0;
          stateNext = (typeReg == RSP_NONE) ? ST_GAP : ST_WAIT;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      ST_WAIT: begin
        rxCrcClr = 1'b1;
        if (!cmd_i) begin
          cntNext   = '0;
          stateNext = ST_RX;
        end else if (cnt == CNT_W'(RSP_TIMEOUT - 1)) begin
          timeoutNext = 1'b1;
          doneNext    = 1'b1;
          busyNext    = 1'b0;
          stateNext   = ST_DONE;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      ST_RX: begin
        rxShiftNext = {rxShift[RX_SHIFT_W-2:0], cmd_i};
        rxCrcEn     = (rxBitNum <= rxCrcHi) && (rxBitNum >= CNT_W'(CRC_LO));
        if (cnt == rxLast) begin
          rspDataNext  = (typeReg == RSP_LONG) ? frameNext : {96'h0, frameNext[39:8]};
          crcErrNext   = (typeReg != RSP_SHORT_NOCRC) && (rxCrc != frameNext[7:1]);
          indexErrNext = (typeReg == RSP_SHORT) && (frameNext[45:40] != idxReg);
          endErrNext   = ~frameNext[0];
          cntNext      = '0;
          stateNext    = ST_GAP;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          doneNext  = 1'b1;
          busyNext  = 1'b0;
          stateNext = ST_DONE;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        stateNext = ST_IDLE;
      end

      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge sd_clk or posedge sd_rst) begin
    if (sd_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idxReg    <= '0;
      argReg    <= '0;
      typeReg   <= RSP_NONE;
      rxShift   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rsp_data  <= '0;
      timeout   <= 1'b0;
      crc_err   <= 1'b0;
      index_err <= 1'b0;
      end_err   <= 1'b0;
      cmd_o     <= 1'b1;
      cmd_oe    <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      idxReg    <= idxNext;
      argReg    <= argNext;
      typeReg   <= typeNext;
      rxShift   <= rxShiftNext;
      busy      <= busyNext;
      done      <= doneNext;
      rsp_data  <= rspDataNext;
      timeout   <= timeoutNext;
      crc_err   <= crcErrNext;
      index_err <= indexErrNext;
      end_err   <= endErrNext;
      cmd_o     <= cmdONext;
      cmd_oe    <= cmdOeNext;
    end
  end

endmodule

// File: tb/tb_sdc_cmd_serial.sv
// Directed bench for sdc_cmd_serial: cycle-exact frame, latency and response-check scenarios.
module tb_sdc_cmd_serial;

  localparam int unsigned RSP_TIMEOUT = 64;
  localparam int unsigned GAP_CYCLES  = 8;
  localparam int unsigned TURN_CYCLES = 2;

  logic         sd_clk = 1'b0;
  logic         sd_rst = 1'b1;
  logic         cmd_start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   rsp_type = '0;
  logic         busy, done, timeout, crc_err, index_err, end_err, cmd_o, cmd_oe;
  logic [127:0] rsp_data;
  logic         cmd_i = 1'b1;

  int checks = 0;
  int failures = 0;

  // observations from the most recent run_cmd
  logic [47:0] txFrame;
  int          doneCycle;
  int          oeErrs;
  logic        busyAtStart;
  logic        busyAtDone;

  always #5 sd_clk = ~sd_clk;

  sdc_cmd_serial #(
    .RSP_TIMEOUT (RSP_TIMEOUT),
    .GAP_CYCLES  (GAP_CYCLES),
    .TURN_CYCLES (TURN_CYCLES)
  ) dut (
    .sd_clk    (sd_clk),
    .sd_rst    (sd_rst),
    .cmd_start (cmd_start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .rsp_type  (rsp_type),
    .busy      (busy),
    .done      (done),
    .rsp_data  (rsp_data),
    .timeout   (timeout),
    .crc_err   (crc_err),
    .index_err (index_err),
    .end_err   (end_err),
    .cmd_o     (cmd_o),
    .cmd_oe    (cmd_oe),
    .cmd_i     (cmd_i)
  );

  // reference CRC7 over the low n bits of data, MSB first
  function automatic logic [6:0] crc7(input logic [127:0] data, input int n);
    logic [6:0] c = '0;
    logic       fb;
    for (int i = n - 1; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Cycle 0 holds cmd_start; cycle k>=1 is observed and driven at its falling edge.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input logic [135:0] frame, input int frameLen, input int rspStart,
                         input int extraPulse, input bit pulseInDone);
    cmd_index = idx;
    cmd_arg   = arg;
    rsp_type  = typ;
    txFrame   = '0;
    doneCycle = -1;
    oeErrs    = 0;
    busyAtStart = 1'b0;
    busyAtDone  = 1'b1;
    @(negedge sd_clk);
    cmd_start = 1'b1;
    for (int k = 1; k <= 400 && doneCycle < 0; k++) begin
      @(negedge sd_clk);
      cmd_start = (k == extraPulse);
      if (k <= 48) begin
        txFrame = {txFrame[46:0], cmd_o};
        if (cmd_oe !== 1'b1) oeErrs++;
      end else if (cmd_oe !== 1'b0) begin
        oeErrs++;
      end
      if (k == 1) busyAtStart = busy;
      if (frameLen > 0 && k >= rspStart && k < rspStart + frameLen)
        cmd_i = frame[frameLen - 1 - (k - rspStart)];
      else
        cmd_i = 1'b1;
      if (done === 1'b1) begin
        doneCycle  = k;
        busyAtDone = busy;
        cmd_start  = pulseInDone;
      end
    end
    if (pulseInDone) @(negedge sd_clk);
    cmd_start = 1'b0;
    cmd_i     = 1'b1;
  endtask

  task automatic test_reset();
    sd_rst = 1'b1;
    repeat (2) @(negedge sd_clk);
    checks++;
    if ({busy, done, cmd_o, cmd_oe} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/cmd_o/cmd_oe got %b want 0010", {busy, done, cmd_o, cmd_oe});
    end
    checks++;
    if ({timeout, crc_err, index_err, end_err} !== 4'b0000 || rsp_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_status: flags got %b rsp_data got %h want 0", {timeout, crc_err, index_err, end_err}, rsp_data);
    end
    sd_rst = 1'b0;
    @(negedge sd_clk);
  endtask

  task automatic test_cmd0();
    run_cmd(6'd0, 32'h0, 2'd0, '0, 0, 0, 0, 1'b0);
    checks++;
    if (txFrame !== 48'h400000000095) begin
      failures++; $display("FAIL cmd0_frame: got %h want 400000000095", txFrame);
    end
    checks++;
    if (doneCycle != 48 + TURN_CYCLES + GAP_CYCLES + 1) begin
      failures++; $display("FAIL cmd0_latency: got %0d want %0d", doneCycle, 48 + TURN_CYCLES + GAP_CYCLES + 1);
    end
    checks++;
    if (oeErrs != 0 || busyAtStart !== 1'b1 || busyAtDone !== 1'b0) begin
      failures++; $display("FAIL cmd0_oe_busy: oeErrs %0d busyStart %b busyDone %b want 0 1 0", oeErrs, busyAtStart, busyAtDone);
    end
    checks++;
    if ({timeout, crc_err, index_err, end_err} !== 4'b0000) begin
      failures++; $display("FAIL cmd0_flags: got %b want 0000", {timeout, crc_err, index_err, end_err});
    end
  endtask

  task automatic test_cmd8();
    run_cmd(6'd8, 32'h1AA, 2'd1, 136'h08000001AA13, 48, 56, 0, 1'b0);
    checks++;
    if (txFrame !== 48'h48000001AA87) begin
      failures++; $display("FAIL cmd8_frame: got %h want 48000001aa87", txFrame);
    end
    checks++;
    if (doneCycle != 112) begin
      failures++; $display("FAIL cmd8_latency: got %0d want 112", doneCycle);
    end
    checks++;
    if (rsp_data !== 128'h1AA || {timeout, crc_err, index_err, end_err} !== 4'b0000) begin
      failures++; $display("FAIL cmd8_rsp: data %h flags %b want 1aa 0000", rsp_data, {timeout, crc_err, index_err, end_err});
    end
  endtask

  task automatic test_rsp_errors();
    logic [135:0] fr;
    run_cmd(6'd8, 32'h1AA, 2'd1, 136'h08000001AA11, 48, 56, 0, 1'b0);
    checks++;
    if (crc_err !== 1'b1 || index_err !== 1'b0 || end_err !== 1'b0 || rsp_data !== 128'h1AA) begin
      failures++; $display("FAIL bad_crc: crc/idx/end %b data %h want 100 1aa", {crc_err, index_err, end_err}, rsp_data);
    end
    fr = '0;
    fr[47:0] = {2'b00, 6'h09, 32'h1AA, crc7({88'h0, 2'b00, 6'h09, 32'h1AA}, 40), 1'b1};
    run_cmd(6'd8, 32'h1AA, 2'd1, fr, 48, 56, 0, 1'b0);
    checks++;
    if (index_err !== 1'b1 || crc_err !== 1'b0 || end_err !== 1'b0) begin
      failures++; $display("FAIL bad_index: crc/idx/end %b want 010", {crc_err, index_err, end_err});
    end
    run_cmd(6'd8, 32'h1AA, 2'd1, 136'h08000001AA12, 48, 56, 0, 1'b0);
    checks++;
    if (end_err !== 1'b1 || crc_err !== 1'b0 || index_err !== 1'b0) begin
      failures++; $display("FAIL bad_end: crc/idx/end %b want 001", {crc_err, index_err, end_err});
    end
  endtask

  task automatic test_timeout();
    int strayBusy;
    run_cmd(6'd8, 32'h1AA, 2'd1, '0, 0, 0, 20, 1'b1);
    checks++;
    if (doneCycle != 48 + TURN_CYCLES + 1 + RSP_TIMEOUT) begin
      failures++; $display("FAIL timeout_latency: got %0d want %0d", doneCycle, 48 + TURN_CYCLES + 1 + RSP_TIMEOUT);
    end
    checks++;
    if (txFrame !== 48'h48000001AA87) begin
      failures++; $display("FAIL timeout_frame: got %h want 48000001aa87", txFrame);
    end
    checks++;
    if ({timeout, crc_err, index_err, end_err} !== 4'b1000 || rsp_data !== 128'h0) begin
      failures++; $display("FAIL timeout_flags: flags %b data %h want 1000 0", {timeout, crc_err, index_err, end_err}, rsp_data);
    end
    strayBusy = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0 || cmd_oe !== 1'b0 || timeout !== 1'b1) strayBusy++;
      @(negedge sd_clk);
    end
    checks++;
    if (strayBusy != 0) begin
      failures++; $display("FAIL done_cycle_start: got %0d busy/oe cycles want 0", strayBusy);
    end
  endtask

  task automatic test_r3_r2();
    logic [119:0] payload;
    logic [6:0]   c;
    logic [135:0] fr;
    fr = '0;
    fr[47:0] = {2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1};
    run_cmd(6'd41, 32'h40FF8000, 2'd3, fr, 48, 56, 0, 1'b0);
    checks++;
    if (rsp_data !== 128'h80FF8000 || {timeout, crc_err, index_err, end_err} !== 4'b0000 || doneCycle != 112) begin
      failures++; $display("FAIL r3: data %h flags %b done %0d want 80ff8000 0000 112", rsp_data, {timeout, crc_err, index_err, end_err}, doneCycle);
    end
    payload = 120'h0123456789ABCDEFFEDCBA98765432;
    c = crc7({8'h0, payload}, 120);
    fr = {2'b00, 6'h3F, payload, c, 1'b1};
    run_cmd(6'd2, 32'h0, 2'd2, fr, 136, 56, 0, 1'b0);
    checks++;
    if (rsp_data !== {payload, c, 1'b1}) begin
      failures++; $display("FAIL r2_data: got %h want %h", rsp_data, {payload, c, 1'b1});
    end
    checks++;
    if ({timeout, crc_err, index_err, end_err} !== 4'b0000 || doneCycle != 200) begin
      failures++; $display("FAIL r2_status: flags %b done %0d want 0000 200", {timeout, crc_err, index_err, end_err}, doneCycle);
    end
  endtask

  task automatic test_reset_mid_tx();
    cmd_index = 6'd8;
    cmd_arg   = 32'h1AA;
    rsp_type  = 2'd1;
    @(negedge sd_clk);
    cmd_start = 1'b1;
    @(negedge sd_clk);
    cmd_start = 1'b0;
    repeat (20) @(negedge sd_clk);
    sd_rst = 1'b1;
    #1;
    checks++;
    if (cmd_oe !== 1'b0 || cmd_o !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset: oe/o/busy got %b%b%b want 010", cmd_oe, cmd_o, busy);
    end
    @(negedge sd_clk);
    sd_rst = 1'b0;
    @(negedge sd_clk);
    run_cmd(6'd0, 32'h0, 2'd0, '0, 0, 0, 0, 1'b0);
    checks++;
    if (txFrame !== 48'h400000000095 || doneCycle != 59) begin
      failures++; $display("FAIL post_reset_cmd0: frame %h done %0d want 400000000095 59", txFrame, doneCycle);
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_rsp_errors();
    test_timeout();
    test_r3_r2();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
